// File: rtl/tiny16_sys_ctrl_if.sv
// tiny16_sys_ctrl_if: tiny16 CPU memory bus as seen by the system controller
interface tiny16_sys_ctrl_if;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        nwr;
    logic        mem_valid;
    logic        mem_ready;
    logic        sel;
    modport master (output address, data_in, nwr, mem_valid, input data_out, mem_ready, sel);
    modport slave  (input address, data_in, nwr, mem_valid, output data_out, mem_ready, sel);
endinterface

// File: rtl/tiny16_sys_ctrl.sv
// tiny16_sys_ctrl: reset sequencer, periodic timer irqs, GPIO and wait-state bus responder
// Define TINY16_SYS_CTRL_AUTOACK_EN to let in_interrupt rising edges acknowledge the lowest pending irq.
module tiny16_sys_ctrl #(
    parameter logic [15:0] BASE_ADDR        = 16'hFF00,
    parameter int          GPIO_WIDTH       = 8,
    parameter int          TIMER_CHANNELS   = 2,
    parameter int          TIMER_BITS       = 16,
    parameter int          WAIT_STATES      = 0,
    parameter int          CPU_RESET_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    tiny16_sys_ctrl_if.slave      bus,
    input  logic                  in_interrupt,
    output logic                  interrupt,
    output logic                  cpu_nreset,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    input  logic [GPIO_WIDTH-1:0] gpio_in
);
    localparam int RW = $clog2(CPU_RESET_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT, READY, DONE} state_t;

    state_t                                    state, state_nx;
    logic [RW-1:0]                             rst_cnt;
    logic [3:0]                                wait_cnt;
    logic [3:0]                                off;
    logic [15:0]                               wdata;
    logic [15:0]                               rdata;
    logic                                      wr;
    logic                                      commit;
    logic [GPIO_WIDTH-1:0]                     gpio_s1, gpio_s2;
    logic [TIMER_CHANNELS-1:0]                 irq_status, irq_enable, timer_enable;
    logic [TIMER_CHANNELS-1:0]                 fire, w1c, ack;
    logic [TIMER_CHANNELS-1:0][TIMER_BITS-1:0] reload_v;

    assign bus.sel       = bus.mem_valid && (bus.address[15:4] == BASE_ADDR[15:4]);
    assign bus.mem_ready = state == READY;
    assign bus.data_out  = (state == READY) ? rdata : 16'h0;
    assign commit        = (state == READY) && wr;
    assign w1c           = (commit && off == 4'd2) ? wdata[TIMER_CHANNELS-1:0] : '0;

    // CPU is held in reset for a fixed number of cycles after nreset release
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            rst_cnt    <= '0;
            cpu_nreset <= 1'b0;
        end else if (!cpu_nreset) begin
            rst_cnt    <= rst_cnt + 1'b1;
            cpu_nreset <= rst_cnt == RW'(CPU_RESET_CYCLES - 1);
        end

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.sel) state_nx = (WAIT_STATES == 0) ? READY : WAIT;
            WAIT:    if (wait_cnt == 4'(WAIT_STATES - 1)) state_nx = READY;
            READY:   state_nx = DONE;
            DONE:    if (!bus.mem_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            off      <= '0;
            wdata    <= '0;
            wr       <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (state == IDLE && bus.sel) begin
                off   <= bus.address[3:0];
                wdata <= bus.data_in;
                wr    <= !bus.nwr;
            end
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : 4'd0;
        end

    always_comb begin
        rdata = '0;
        case (off)
            4'd0: rdata = 16'(gpio_out);
            4'd1: rdata = 16'(gpio_s2);
            4'd2: rdata = 16'(irq_status);
            4'd3: rdata = 16'(irq_enable);
            4'd4: rdata = 16'(timer_enable);
            default:
                for (int i = 0; i < TIMER_CHANNELS; i++)
                    if (int'(off) == 5 + i) rdata = 16'(reload_v[i]);
        endcase
    end

    // A timer set in the same cycle as a clear (W1C or auto-ack) keeps the bit set
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            gpio_out     <= '0;
            gpio_s1      <= '0;
            gpio_s2      <= '0;
            irq_status   <= '0;
            irq_enable   <= '0;
            timer_enable <= '0;
            interrupt    <= 1'b0;
        end else begin
            gpio_s1    <= gpio_in;
            gpio_s2    <= gpio_s1;
            if (commit && off == 4'd0) gpio_out <= wdata[GPIO_WIDTH-1:0];
            if (commit && off == 4'd3) irq_enable <= wdata[TIMER_CHANNELS-1:0];
            if (commit && off == 4'd4) timer_enable <= wdata[TIMER_CHANNELS-1:0];
            irq_status <= (irq_status & ~(w1c | ack)) | fire;
            interrupt  <= |(irq_status & irq_enable);
        end

    for (genvar g = 0; g < TIMER_CHANNELS; g++) begin : g_tmr
        logic [TIMER_BITS-1:0] reload, count;
        logic                  load_w, start;
        assign load_w      = commit && int'(off) == 5 + g;
        assign start       = commit && off == 4'd4 && wdata[g] && !timer_enable[g];
        assign fire[g]     = timer_enable[g] && cpu_nreset && count == '0 && !load_w;
        assign reload_v[g] = reload;
        always_ff @(posedge clk or negedge nreset)
            if (!nreset) begin
                reload <= '0;
                count  <= '0;
            end else begin
                if (load_w) reload <= wdata[TIMER_BITS-1:0];
                if (load_w) count <= wdata[TIMER_BITS-1:0];
                else if (start) count <= reload;
                else if (timer_enable[g] && cpu_nreset) count <= (count == '0) ? reload : count - 1'b1;
            end
    end

`ifdef TINY16_SYS_CTRL_AUTOACK_EN
    logic                      in_int_d;
    logic [TIMER_CHANNELS-1:0] pend;
    assign pend = irq_status & irq_enable;
    assign ack  = (in_interrupt && !in_int_d) ? (pend & (~pend + 1'b1)) : '0;
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) in_int_d <= 1'b0;
        else in_int_d <= in_interrupt;
`else
    logic unused_in_interrupt;
    assign unused_in_interrupt = in_interrupt;
    assign ack = '0;
`endif
endmodule

// File: tb/tb_tiny16_sys_ctrl.sv
// tb_tiny16_sys_ctrl: table, directed and random checks of tiny16_sys_ctrl (WAIT_STATES=2, 2 timers)
module tb_tiny16_sys_ctrl;
    localparam int WS  = 2;
    localparam int CRC = 16;
`ifdef TINY16_SYS_CTRL_AUTOACK_EN
    localparam bit AA = 1'b1;
`else
    localparam bit AA = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       in_interrupt = 1'b0;
    logic       interrupt, cpu_nreset;
    logic [7:0] gpio_out;
    logic [7:0] gpio_in = 8'h3C;
    int         total = 0, bad = 0, cyc = 0;

    logic [15:0] rd, dor;
    int          lat, pulses, rcyc;
    logic        sel0;

    tiny16_sys_ctrl_if bus();

    tiny16_sys_ctrl #(
        .BASE_ADDR(16'hFF00), .GPIO_WIDTH(8), .TIMER_CHANNELS(2),
        .TIMER_BITS(16), .WAIT_STATES(WS), .CPU_RESET_CYCLES(CRC)
    ) dut (
        .clk(clk), .nreset(nreset), .bus(bus), .in_interrupt(in_interrupt),
        .interrupt(interrupt), .cpu_nreset(cpu_nreset), .gpio_out(gpio_out), .gpio_in(gpio_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the bus idle again
    task automatic access(input logic [15:0] a, input logic [15:0] d, input logic w);
        bus.address = a; bus.data_in = d; bus.nwr = !w; bus.mem_valid = 1'b1;
        lat = -1; pulses = 0; rd = '0; dor = '0; rcyc = 0;
        #1 sel0 = bus.sel;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            dor |= bus.data_out;
            if (bus.mem_ready) begin
                pulses++;
                if (lat < 0) begin lat = i; rd = bus.data_out; rcyc = cyc; end
            end
        end
        bus.mem_valid = 1'b0; bus.nwr = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_wr(input logic [15:0] a, input logic [15:0] d, input string nm);
        access(a, d, 1'b1);
        chk({nm, "_lat"}, lat, WS + 1);
        chk({nm, "_pulses"}, pulses, 1);
    endtask

    task automatic do_rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
        access(a, 16'h0, 1'b0);
        chk({nm, "_lat"}, lat, WS + 1);
        chk({nm, "_pulses"}, pulses, 1);
        chk({nm, "_data"}, rd, exp);
    endtask

    task automatic wait_cyc(input int t, input string nm);
        for (int i = 0; i < 200 && cyc < t; i++) @(negedge clk);
        chk({nm, "_align"}, cyc, t);
    endtask

    // Called at a negedge with nreset low; releases it and tracks cpu_nreset
    task automatic release_reset(input string nm);
        int first = -1;
        int early = 0, drop = 0, rdy = 0;
        nreset = 1'b1;
        for (int k = 1; k <= CRC + 8; k++) begin
            @(negedge clk);
            if (k < CRC && (interrupt || gpio_out != 0 || bus.data_out != 0)) early++;
            if (bus.mem_ready) rdy++;
            if (first >= 0 && !cpu_nreset) drop++;
            if (cpu_nreset && first < 0) first = k;
        end
        chk({nm, "_cpu_nreset_rise"}, first, CRC);
        chk({nm, "_outputs_low"}, early, 0);
        chk({nm, "_cpu_nreset_stays"}, drop, 0);
        chk({nm, "_no_ready"}, rdy, 0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic        w;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl[14];
    logic [15:0] model[16];
    logic [15:0] mask[16];
    int          c, w;

    initial begin
        tbl = '{
            '{16'hFF00, 16'h00A5, 1'b1, 16'h0000},
            '{16'hFF00, 16'h0000, 1'b0, 16'h00A5},
            '{16'hFF03, 16'hFFFF, 1'b1, 16'h0000},
            '{16'hFF03, 16'h0000, 1'b0, 16'h0003},
            '{16'hFF05, 16'h1234, 1'b1, 16'h0000},
            '{16'hFF05, 16'h0000, 1'b0, 16'h1234},
            '{16'hFF0F, 16'h5555, 1'b1, 16'h0000},
            '{16'hFF0F, 16'h0000, 1'b0, 16'h0000},
            '{16'hFF01, 16'h0000, 1'b0, 16'h003C},
            '{16'hFF01, 16'hFFFF, 1'b1, 16'h003C},
            '{16'hFF01, 16'h0000, 1'b0, 16'h003C},
            '{16'hFF07, 16'h0000, 1'b0, 16'h0000},
            '{16'hFF06, 16'hBEEF, 1'b1, 16'h0000},
            '{16'hFF06, 16'h0000, 1'b0, 16'hBEEF}
        };
        bus.address = '0; bus.data_in = '0; bus.nwr = 1'b1; bus.mem_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cpu_nreset", cpu_nreset, 0);
        chk("rst_interrupt", interrupt, 0);
        chk("rst_gpio_out", gpio_out, 0);
        chk("rst_mem_ready", bus.mem_ready, 0);
        release_reset("boot");

        for (int i = 0; i < 14; i++) begin
            access(tbl[i].a, tbl[i].d, tbl[i].w);
            chk($sformatf("tbl%0d_sel", i), sel0, 1);
            chk($sformatf("tbl%0d_lat", i), lat, WS + 1);
            chk($sformatf("tbl%0d_pulses", i), pulses, 1);
            chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp);
        end
        chk("tbl_gpio_out", gpio_out, 8'hA5);

        access(16'hFE00, 16'h0011, 1'b1);
        chk("oow_sel", sel0, 0);
        chk("oow_pulses", pulses, 0);
        chk("oow_data_out", dor, 0);
        chk("oow_gpio_out", gpio_out, 8'hA5);

        // Timer 0 period 10: fires at edges c+11+10k, interrupt follows one edge later
        do_wr(16'hFF05, 16'd9, "t_reload");
        do_wr(16'hFF03, 16'd1, "t_irqen");
        do_wr(16'hFF04, 16'd1, "t_enable");
        c = rcyc;
        chk("t_irq_quiet", interrupt, 0);
        for (int i = 0; i < 40 && !interrupt; i++) @(negedge clk);
        chk("t_first_irq", cyc, c + 12);
        w = c + 24;
        wait_cyc(w - 4, "t_w1c");
        do_wr(16'hFF02, 16'd1, "t_w1c");
        chk("t_w1c_drop", interrupt, 0);
        for (int i = 0; i < 40 && !interrupt; i++) @(negedge clk);
        chk("t_next_irq", cyc, c + 11 + 10 * ((w - (c + 11)) / 10 + 1) + 1);
        wait_cyc(c + 41 - 4, "t_coinc");
        do_wr(16'hFF02, 16'd1, "t_coinc");
        chk("t_set_wins", interrupt, 1);

        // Both channels pending, then frozen for the acknowledge test
        do_wr(16'hFF05, 16'd0, "a_reload0");
        do_wr(16'hFF06, 16'd0, "a_reload1");
        do_wr(16'hFF03, 16'd3, "a_irqen");
        do_wr(16'hFF04, 16'd3, "a_en");
        do_wr(16'hFF04, 16'd0, "a_dis");
        do_rd(16'hFF02, 16'd3, "a_pend");
        chk("a_irq", interrupt, 1);
        for (int p = 0; p < 2; p++) begin
            in_interrupt = 1'b1;
            repeat (2) @(negedge clk);
            in_interrupt = 1'b0;
            @(negedge clk);
            do_rd(16'hFF02, AA ? 16'(3 >> (p + 1) << (p + 1)) : 16'd3, $sformatf("a_ack%0d", p));
        end
        chk("a_irq_after", interrupt, AA ? 0 : 1);

        // Reset during WAIT aborts the access
        bus.address = 16'hFF00; bus.data_in = 16'h005A; bus.nwr = 1'b0; bus.mem_valid = 1'b1;
        @(negedge clk);
        chk("mw_pre_ready", bus.mem_ready, 0);
        nreset = 1'b0; bus.mem_valid = 1'b0; bus.nwr = 1'b1;
        #1;
        chk("mw_gpio_out", gpio_out, 0);
        chk("mw_cpu_nreset", cpu_nreset, 0);
        chk("mw_interrupt", interrupt, 0);
        chk("mw_ready", bus.mem_ready, 0);
        repeat (3) @(negedge clk);
        release_reset("mw");
        for (int o = 0; o < 7; o++)
            if (o != 1) do_rd(16'hFF00 | 16'(o), 16'h0, $sformatf("mw_reg%0d", o));

        // Random accesses against an offset->value model of the register file
        for (int o = 0; o < 16; o++) begin
            model[o] = '0;
            mask[o]  = (o == 0) ? 16'h00FF : (o == 3) ? 16'h0003 : (o == 5 || o == 6) ? 16'hFFFF : 16'h0;
        end
        for (int i = 0; i < 40; i++) begin
            int          o;
            logic [15:0] d, exp;
            logic        wbit;
            o = $urandom_range(0, 15);
            if (o == 4) o = 3;
            d = 16'($urandom);
            wbit = 1'($urandom_range(0, 1));
            gpio_in = 8'($urandom);
            exp = (o == 1) ? 16'(gpio_in) : model[o];
            access(16'hFF00 | 16'(o), d, wbit);
            chk($sformatf("rnd%0d_pulses", i), pulses, 1);
            chk($sformatf("rnd%0d_data_o%0d", i, o), rd, exp);
            if (wbit && mask[o] != 0) model[o] = d & mask[o];
            chk($sformatf("rnd%0d_gpio_out", i), gpio_out, model[0][7:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
